// File: rtl/xconverter_wb_upsize_gen.sv
// xconverter_wb_upsize_gen
// Packs a stream of DWS-bit DMA read beats into DWD-bit write-buffer SRAM
// words. The number of 32-bit lanes per output word (cfg_lanes) is chosen at
// run time. An end-of-transfer beat flushes any residue as a partial word
// with exact byte strobes. The block supports a synchronous abort and pulses
// done when a transfer completes.
//
// Ports:
//   xclk, xreset_n       clock, asynchronous active-low reset
//   start                begins a transfer (honoured only in IDLE)
//   addr_start           first WB word address, sampled on start
//   cfg_lanes            lanes per output word (1..ND), sampled on start
//   abort                synchronous return to IDLE, drops pending data
//   in_valid/in_ready    input beat handshake
//   in_data, in_last     input beat (lane 0 in LSBs) and end-of-transfer flag
//   wb_write/wb_ready    output word handshake towards the SRAM
//   wb_addr, wb_wstrb    word address and byte strobes
//   wb_wdata             packed output word, lane 0 in LSBs
//   busy                 high whenever not IDLE
//   done                 one-cycle pulse when DRAIN returns to IDLE
//   cfg_err              one-cycle pulse when start carries a bad cfg_lanes
module xconverter_wb_upsize_gen #(
    parameter int DWS   = 128,
    parameter int DWD   = 416,
    parameter int AW_WB = 13,
    parameter int CW    = 5
) (
    input  logic               xclk,
    input  logic               xreset_n,
    input  logic               start,
    input  logic [AW_WB-1:0]   addr_start,
    input  logic [CW-1:0]      cfg_lanes,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DWS-1:0]     in_data,
    input  logic               in_last,
    output logic               wb_write,
    input  logic               wb_ready,
    output logic [AW_WB-1:0]   wb_addr,
    output logic [DWD/8-1:0]   wb_wstrb,
    output logic [DWD-1:0]     wb_wdata,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam int NS    = DWS / 32;
    localparam int ND    = DWD / 32;
    localparam int NA    = ND + NS - 1;
    localparam int ACC_W = NA * 32;
    // One extra bit over cfg_lanes so the count can reach ND+NS-1.
    localparam int CNTW  = CW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                done_next;
    logic                cfg_err_next;

    logic [CNTW-1:0]     cnt;
    logic [CW-1:0]       cfg_q;
    logic [ACC_W-1:0]    acc;

    logic [CNTW-1:0]     cfg_ext;
    logic                cfg_ok;
    logic                cnt_ge_cfg;
    logic                out_free;
    logic                accept;
    logic                emit;
    logic [CNTW-1:0]     n_emit;
    logic [CNTW+4:0]     sh_cnt;
    logic [CNTW+4:0]     sh_emit;
    logic [ACC_W-1:0]    beat_ext;
    logic [ACC_W-1:0]    beat_fill;
    logic [DWD-1:0]      emit_data;
    logic [DWD/8-1:0]    emit_strb;

    assign cfg_ext    = {1'b0, cfg_q};
    assign cfg_ok     = (cfg_lanes != '0) && ({1'b0, cfg_lanes} <= CNTW'(ND));
    assign cnt_ge_cfg = (cnt >= cfg_ext);
    assign out_free   = !wb_write || wb_ready;

    // in_ready depends only on registered state, so there is no path from
    // in_valid. It also guarantees accept and a full-word emit never coincide.
    assign in_ready = (state == RUN) && !cnt_ge_cfg;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    // Emit a full word when enough lanes are collected. During DRAIN, any
    // residue goes out as one partial word.
    assign emit   = (state != IDLE) && out_free &&
                    (cnt_ge_cfg || ((state == DRAIN) && (cnt != '0)));
    assign n_emit = cnt_ge_cfg ? cfg_ext : cnt;

    // Lane-granular shift amounts (lanes * 32 bits).
    assign sh_cnt  = {cnt, 5'b0};
    assign sh_emit = {n_emit, 5'b0};

    // The beat is widened to accumulator width so it can be dropped in at
    // lane position cnt. The fill mask clears those lanes first.
    always_comb begin
        beat_ext            = '0;
        beat_fill           = '0;
        beat_ext[DWS-1:0]   = in_data;
        beat_fill[DWS-1:0]  = '1;
    end

    // Build the outgoing word: the lowest n_emit lanes of the accumulator go
    // out, and all lanes and strobes above them are forced to zero.
    always_comb begin
        emit_data = '0;
        emit_strb = '0;
        for (int l = 0; l < ND; l++) begin
            if (CNTW'(l) < n_emit) begin
                emit_data[32*l +: 32] = acc[32*l +: 32];
                emit_strb[4*l +: 4]   = 4'hF;
            end
        end
    end

    // Next-state logic. abort overrides every other transition and
    // suppresses both pulses.
    always_comb begin
        state_next   = state;
        done_next    = 1'b0;
        cfg_err_next = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        state_next = RUN;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept && in_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((cnt == '0) && out_free) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort) begin
            state_next   = IDLE;
            done_next    = 1'b0;
            cfg_err_next = 1'b0;
        end
    end

    always_ff @(posedge xclk or negedge xreset_n) begin
        if (!xreset_n) begin
            state   <= IDLE;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_next;
            done    <= done_next;
            cfg_err <= cfg_err_next;
        end
    end

    // Datapath. The accumulator keeps unused upper lanes at zero: a shift
    // brings zeros in, and abort or start clears it.
    always_ff @(posedge xclk or negedge xreset_n) begin
        if (!xreset_n) begin
            cnt      <= '0;
            cfg_q    <= '0;
            acc      <= '0;
            wb_write <= 1'b0;
            wb_addr  <= '0;
            wb_wstrb <= '0;
            wb_wdata <= '0;
        end else if (abort) begin
            cnt      <= '0;
            acc      <= '0;
            wb_write <= 1'b0;
            wb_wstrb <= '0;
            wb_wdata <= '0;
        end else begin
            if ((state == IDLE) && start && cfg_ok) begin
                cfg_q <= cfg_lanes;
                cnt   <= '0;
                acc   <= '0;
            end else if (accept) begin
                acc <= (acc & ~(beat_fill << sh_cnt)) | (beat_ext << sh_cnt);
                cnt <= cnt + CNTW'(NS);
            end else if (emit) begin
                acc <= acc >> sh_emit;
                cnt <= cnt - n_emit;
            end

            if (emit) begin
                wb_write <= 1'b1;
                wb_wdata <= emit_data;
                wb_wstrb <= emit_strb;
            end else if (wb_write && wb_ready) begin
                wb_write <= 1'b0;
            end

            // The address advances after each accepted word. It is reloaded
            // only from IDLE, when no word can be pending.
            if ((state == IDLE) && start && cfg_ok) begin
                wb_addr <= addr_start;
            end else if (wb_write && wb_ready) begin
                wb_addr <= wb_addr + AW_WB'(1);
            end
        end
    end

endmodule

// File: tb/tb_xconverter_wb_upsize_gen.sv
// Testbench for xconverter_wb_upsize_gen.
// Each transfer first pushes its expected WB words into a queue. A monitor
// then pops and compares every word the DUT hands to the SRAM. The monitor
// also checks that the output holds steady while the SRAM stalls.
module tb_xconverter_wb_upsize_gen;

    localparam int DWS   = 128;
    localparam int DWD   = 416;
    localparam int AW_WB = 13;
    localparam int CW    = 5;

    typedef struct {
        logic [AW_WB-1:0] addr;
        logic [DWD-1:0]   data;
        logic [DWD/8-1:0] strb;
    } exp_t;

    logic               xclk = 1'b0;
    logic               xreset_n;
    logic               start;
    logic [AW_WB-1:0]   addr_start;
    logic [CW-1:0]      cfg_lanes;
    logic               abort;
    logic               in_valid;
    logic               in_ready;
    logic [DWS-1:0]     in_data;
    logic               in_last;
    logic               wb_write;
    logic               wb_ready;
    logic [AW_WB-1:0]   wb_addr;
    logic [DWD/8-1:0]   wb_wstrb;
    logic [DWD-1:0]     wb_wdata;
    logic               busy;
    logic               done;
    logic               cfg_err;

    exp_t exp_q[$];
    int   total_checks = 0;
    int   passed_checks = 0;
    int   cyc = 0;
    int   accepts = 0;
    int   first_acc = -1;
    int   last_acc = -1;
    int   done_seen = 0;
    int   done_exp = 0;

    logic               stall_prev = 1'b0;
    logic [AW_WB-1:0]   prev_addr;
    logic [DWD-1:0]     prev_data;
    logic [DWD/8-1:0]   prev_strb;

    xconverter_wb_upsize_gen #(
        .DWS(DWS), .DWD(DWD), .AW_WB(AW_WB), .CW(CW)
    ) dut (
        .xclk(xclk), .xreset_n(xreset_n), .start(start),
        .addr_start(addr_start), .cfg_lanes(cfg_lanes), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .wb_write(wb_write), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_wstrb(wb_wstrb), .wb_wdata(wb_wdata),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 xclk = ~xclk;

    always @(posedge xclk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_checks++;
        if (got === exp) passed_checks++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic checkData(input string name, input logic [DWD-1:0] got, input logic [DWD-1:0] exp);
        total_checks++;
        if (got === exp) passed_checks++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Monitor: compares handshaken words against the queue, checks that the
    // output holds during a stall, and tracks accepted beats and done pulses.
    always @(negedge xclk) begin
        if (xreset_n) begin
            if (stall_prev) begin
                checkOutput("hold_write", 64'(wb_write), 64'd1);
                checkOutput("hold_addr", 64'(wb_addr), 64'(prev_addr));
                checkOutput("hold_strb", 64'(wb_wstrb), 64'(prev_strb));
                checkData("hold_data", wb_wdata, prev_data);
            end
            if (wb_write && wb_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write_addr", 64'(wb_addr), 64'h0);
                    total_checks++;
                    $display("[TB] FAIL unexpected_write: got a write, expected none");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("wb_addr", 64'(wb_addr), 64'(e.addr));
                    checkOutput("wb_wstrb", 64'(wb_wstrb), 64'(e.strb));
                    checkData("wb_wdata", wb_wdata, e.data);
                end
            end
            stall_prev = wb_write && !wb_ready;
            prev_addr  = wb_addr;
            prev_data  = wb_wdata;
            prev_strb  = wb_wstrb;
            if (in_valid && in_ready) begin
                accepts++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (done) done_seen++;
        end
    end

    // Expected-word model: lane j of the transfer carries value base+j. The
    // words are full cfg-lane chunks, and any remainder becomes a partial word.
    task automatic pushWords(input int cfg, input int addr, input int nbeats, input logic [31:0] base);
        int total;
        int nw;
        total = 4 * nbeats;
        nw = (total + cfg - 1) / cfg;
        for (int w = 0; w < nw; w++) begin
            exp_t e;
            int n;
            n = (total - w * cfg < cfg) ? (total - w * cfg) : cfg;
            e.addr = AW_WB'(addr + w);
            e.data = '0;
            e.strb = '0;
            for (int i = 0; i < n; i++) e.data[32*i +: 32] = base + 32'(w * cfg + i);
            for (int i = 0; i < 4 * n; i++) e.strb[i] = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic issueStart(input int cfg, input int addr);
        @(posedge xclk); #1;
        start      = 1'b1;
        cfg_lanes  = CW'(cfg);
        addr_start = AW_WB'(addr);
        @(posedge xclk); #1;
        start = 1'b0;
    endtask

    task automatic sendBeat(input logic [DWS-1:0] d, input logic last);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge xclk);
            if (in_ready) begin
                @(posedge xclk); #1;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            total_checks++;
            $display("[TB] FAIL beat_timeout: got no in_ready, expected acceptance");
        end
    endtask

    function automatic logic [DWS-1:0] beatData(input logic [31:0] base, input int b);
        logic [DWS-1:0] d;
        for (int k = 0; k < DWS / 32; k++) d[32*k +: 32] = base + 32'(4 * b + k);
        return d;
    endfunction

    task automatic waitDone();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge xclk);
            if (done_seen >= done_exp) ok = 1'b1;
        end
        checkOutput("done_count", 64'(done_seen), 64'(done_exp));
        @(negedge xclk);
        checkOutput("done_pulse_low", 64'(done), 64'd0);
        checkOutput("busy_after_done", 64'(busy), 64'd0);
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic applyStimulus(input int cfg, input int addr, input int nbeats, input logic [31:0] base);
        pushWords(cfg, addr, nbeats, base);
        done_exp++;
        accepts   = 0;
        first_acc = -1;
        last_acc  = -1;
        issueStart(cfg, addr);
        for (int b = 0; b < nbeats; b++) sendBeat(beatData(base, b), b == nbeats - 1);
        waitDone();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        xreset_n   = 1'b0;
        start      = 1'b0;
        addr_start = '0;
        cfg_lanes  = '0;
        abort      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        wb_ready   = 1'b1;

        repeat (3) @(negedge xclk);
        checkOutput("rst_wb_write", 64'(wb_write), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_cfg_err", 64'(cfg_err), 64'd0);
        checkOutput("rst_wb_addr", 64'(wb_addr), 64'd0);
        checkOutput("rst_wb_wstrb", 64'(wb_wstrb), 64'd0);
        checkData("rst_wb_wdata", wb_wdata, '0);
        @(posedge xclk); #1;
        xreset_n = 1'b1;

        // Both bad configurations must be rejected: lanes 0 and lanes 14.
        issueStart(0, 'h055);
        @(negedge xclk);
        checkOutput("cfg0_err", 64'(cfg_err), 64'd1);
        checkOutput("cfg0_busy", 64'(busy), 64'd0);
        @(negedge xclk);
        checkOutput("cfg0_err_pulse", 64'(cfg_err), 64'd0);
        issueStart(14, 'h055);
        @(negedge xclk);
        checkOutput("cfg14_err", 64'(cfg_err), 64'd1);
        checkOutput("cfg14_busy", 64'(busy), 64'd0);
        @(negedge xclk);
        checkOutput("cfg14_err_pulse", 64'(cfg_err), 64'd0);

        // 256-bit mode: four beats produce two words.
        applyStimulus(8, 'h010, 4, 32'h1000_0000);

        // 416-bit mode: 13 beats produce four full words. Bubbles appear
        // after beats 4, 7 and 10, so 13 accepts span 16 cycles.
        applyStimulus(13, 'h020, 13, 32'h0000_0000);
        checkOutput("run416_accepts", 64'(accepts), 64'd13);
        checkOutput("run416_span", 64'(last_acc - first_acc), 64'd15);

        // 416-bit mode with a partial flush: 20 lanes give one full word plus 7 lanes.
        applyStimulus(13, 'h040, 5, 32'h2000_0000);

        // The address wraps past the top of the WB.
        applyStimulus(8, 'h1FFF, 4, 32'h3000_0000);

        // SRAM stalls for 10 cycles once the first 416 word appears. Beats 5-7
        // fill the accumulator to 15 lanes, then input is refused.
        wb_ready = 1'b0;
        fork
            applyStimulus(13, 'h080, 13, 32'h5000_0000);
            begin
                bit seen;
                seen = 1'b0;
                for (int t = 0; t < 300 && !seen; t++) begin
                    @(negedge xclk);
                    if (wb_write) seen = 1'b1;
                end
                checkOutput("stall_saw_write", 64'(seen), 64'd1);
                repeat (10) @(posedge xclk);
                #1;
                checkOutput("stall_accepts", 64'(accepts), 64'd7);
                checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
                wb_ready = 1'b1;
            end
        join

        // Abort after two beats. It must win over a simultaneous beat and start.
        issueStart(13, 'h100);
        sendBeat(beatData(32'h6000_0000, 0), 1'b0);
        sendBeat(beatData(32'h6000_0000, 1), 1'b0);
        abort    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = beatData(32'h6000_0000, 2);
        @(posedge xclk); #1;
        abort    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge xclk);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_wb_write", 64'(wb_write), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd0);
        checkOutput("abort_wstrb", 64'(wb_wstrb), 64'd0);
        repeat (5) @(negedge xclk);
        checkOutput("abort_no_done", 64'(done_seen), 64'(done_exp));
        checkOutput("abort_no_write", 64'(exp_q.size()), 64'd0);

        // A clean transfer after the abort must start from an empty accumulator.
        applyStimulus(8, 'h200, 4, 32'h4000_0000);

        $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
